// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM states and fixed register indices.
package cpu_pkg;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_WB
  } mem_state_t;

  localparam logic [3:0] LR_ADDR = 4'd14;
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_access_stage_if.sv
// Word-addressed data RAM port: req held until ack, read data valid with ack.
interface mem_access_stage_if #(
  parameter int ADDR_W = 11
);

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    output ram_ack, ram_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/ARMv4 word rotation.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic        st_we,
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] rot;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    st_be    = BE_WORD;
    st_wdata = st_data;
    rot      = ld_rdata;
    if (st_byte) begin
      st_wdata = {4{st_data[7:0]}};
      if (st_we) st_be = 4'b0001 << st_lane;
    end
    // Unaligned word loads rotate right so the addressed byte lands in bits 7:0.
    unique case (ld_lane)
      2'd0: rot = ld_rdata;
      2'd1: rot = {ld_rdata[7:0],  ld_rdata[31:8]};
      2'd2: rot = {ld_rdata[15:0], ld_rdata[31:16]};
      2'd3: rot = {ld_rdata[23:0], ld_rdata[31:24]};
    endcase
    ld_data = ld_byte ? {24'h0, rot[7:0]} : rot;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: one RAM req/ack transaction per access, timeout abort, load write-back.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic                mem_we,
  input  logic                mem_byte,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_rd,
  mem_access_stage_if.master  ram,
  output logic [31:0]         ram_data2,
  output logic                forward_w_data,
  output logic [3:0]          w_addr1,
  output logic                w_en1,
  output logic                stall,
  output logic                mem_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rd_q;
  logic             byte_q;
  logic [1:0]       lane_q;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;
  logic             unused_addr_hi;

  assign mem_ready      = (state == MS_IDLE);
  assign stall          = (state != MS_IDLE) | (mem_valid & mem_ready);
  assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

  mem_lane_align u_align (
    .st_we    (mem_we),
    .st_byte  (mem_byte),
    .st_lane  (mem_addr[1:0]),
    .st_data  (mem_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_byte  (byte_q),
    .ld_lane  (lane_q),
    .ld_rdata (ram.ram_rdata),
    .ld_data  (ld_data)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values; blocking would race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= MS_IDLE;
      cnt            <= '0;
      rd_q           <= '0;
      byte_q         <= 1'b0;
      lane_q         <= '0;
      ram.ram_req    <= 1'b0;
      ram.ram_we     <= 1'b0;
      ram.ram_addr   <= '0;
      ram.ram_be     <= '0;
      ram.ram_wdata  <= '0;
      ram_data2      <= '0;
      forward_w_data <= 1'b0;
      w_addr1        <= '0;
      w_en1          <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      w_en1          <= 1'b0;
      forward_w_data <= 1'b0;
      mem_err        <= 1'b0;
      unique case (state)
        MS_IDLE: begin
          cnt <= '0;
          if (mem_valid) begin
            state         <= MS_REQ;
            ram.ram_req   <= 1'b1;
            ram.ram_we    <= mem_we;
            ram.ram_addr  <= mem_addr[ADDR_W+1:2];
            ram.ram_be    <= st_be;
            ram.ram_wdata <= st_wdata;
            rd_q          <= mem_rd;
            byte_q        <= mem_byte;
            lane_q        <= mem_addr[1:0];
          end
        end
        MS_REQ: begin
          // An ack on the last allowed cycle still completes the access.
          if (ram.ram_ack) begin
            ram.ram_req <= 1'b0;
            ram.ram_we  <= 1'b0;
            cnt         <= '0;
            if (ram.ram_we) begin
              state <= MS_IDLE;
            end else begin
              state          <= MS_WB;
              ram_data2      <= ld_data;
              w_en1          <= 1'b1;
              forward_w_data <= 1'b1;
              w_addr1        <= rd_q;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= MS_IDLE;
            ram.ram_req <= 1'b0;
            ram.ram_we  <= 1'b0;
            cnt         <= '0;
            mem_err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MS_WB:   state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule
